// File: rtl/alarm_controller.sv
// Alarm sequencer: rings when the running time hits the programmed alarm, then handles
// ring timeout, snooze intervals and the per-event snooze budget off the 1 Hz tick.
module alarm_controller #(
    parameter int unsigned RING_TIMEOUT_S = 60,
    parameter int unsigned SNOOZE_S       = 540,
    parameter int unsigned MAX_SNOOZES    = 3,
    parameter int unsigned SL_W           = $clog2(MAX_SNOOZES + 1)
) (
    input  logic            clk_in,
    input  logic            reset,
    input  logic            tick_1hz,
    input  logic [4:0]      hours,
    input  logic [5:0]      minutes,
    input  logic [5:0]      seconds,
    input  logic [4:0]      alarm_hours,
    input  logic [5:0]      alarm_minutes,
    input  logic            alarm_enable,
    input  logic            snooze_btn,
    input  logic            stop_btn,
    output logic            ringing,
    output logic            snoozed,
    output logic            buzzer,
    output logic [SL_W-1:0] snooze_left,
    output logic            missed
);

    // Guard against zero-width counters for degenerate limits of 1.
    localparam int unsigned RcW = (RING_TIMEOUT_S > 1) ? $clog2(RING_TIMEOUT_S) : 1;
    localparam int unsigned ScW = (SNOOZE_S > 1) ? $clog2(SNOOZE_S) : 1;

    localparam logic [RcW-1:0]  RingLast  = RcW'(RING_TIMEOUT_S - 1);
    localparam logic [ScW-1:0]  SnoozeLast = ScW'(SNOOZE_S - 1);
    localparam logic [SL_W-1:0] SnoozeMax = SL_W'(MAX_SNOOZES);

    typedef enum logic [1:0] {
        StIdle,
        StRinging,
        StSnoozed
    } state_e;

    state_e          state_q, state_d;
    logic [RcW-1:0]  ring_cnt_q, ring_cnt_d;
    logic [ScW-1:0]  snooze_cnt_q, snooze_cnt_d;
    logic            beep_q, beep_d;
    logic [SL_W-1:0] left_q, left_d;
    logic            missed_q, missed_d;
    logic            buzzer_q, buzzer_d;
    logic            snooze_hist_q, stop_hist_q;

    logic snooze_edge, stop_edge, alarm_match;

    assign snooze_edge = snooze_btn & ~snooze_hist_q;
    assign stop_edge   = stop_btn & ~stop_hist_q;
    assign alarm_match = (hours == alarm_hours) && (minutes == alarm_minutes) &&
                         (seconds == 6'd0);

    always_comb begin
        state_d      = state_q;
        ring_cnt_d   = ring_cnt_q;
        snooze_cnt_d = snooze_cnt_q;
        beep_d       = beep_q;
        left_d       = left_q;
        missed_d     = 1'b0;

        if (!alarm_enable) begin
            state_d      = StIdle;
            left_d       = SnoozeMax;
            ring_cnt_d   = '0;
            snooze_cnt_d = '0;
            beep_d       = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (tick_1hz && alarm_match) begin
                        state_d    = StRinging;
                        ring_cnt_d = '0;
                        beep_d     = 1'b1;
                    end
                end
                StRinging: begin
                    if (stop_edge) begin
                        state_d    = StIdle;
                        left_d     = SnoozeMax;
                        ring_cnt_d = '0;
                        beep_d     = 1'b0;
                    end else if (snooze_edge && (left_q != '0)) begin
                        state_d      = StSnoozed;
                        left_d       = left_q - 1'b1;
                        snooze_cnt_d = '0;
                    end else if (tick_1hz) begin
                        if (ring_cnt_q == RingLast) begin
                            state_d    = StIdle;
                            missed_d   = 1'b1;
                            left_d     = SnoozeMax;
                            ring_cnt_d = '0;
                            beep_d     = 1'b0;
                        end else begin
                            ring_cnt_d = ring_cnt_q + 1'b1;
                            beep_d     = ~beep_q;
                        end
                    end
                end
                StSnoozed: begin
                    if (stop_edge) begin
                        state_d      = StIdle;
                        left_d       = SnoozeMax;
                        snooze_cnt_d = '0;
                        beep_d       = 1'b0;
                    end else if (tick_1hz) begin
                        if (snooze_cnt_q == SnoozeLast) begin
                            state_d      = StRinging;
                            snooze_cnt_d = '0;
                            ring_cnt_d   = '0;
                            beep_d       = 1'b1;
                        end else begin
                            snooze_cnt_d = snooze_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        buzzer_d = (state_d == StRinging) && beep_d;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            ring_cnt_q    <= '0;
            snooze_cnt_q  <= '0;
            beep_q        <= 1'b0;
            left_q        <= SnoozeMax;
            missed_q      <= 1'b0;
            buzzer_q      <= 1'b0;
            // History starts high so a button held through reset gives no edge.
            snooze_hist_q <= 1'b1;
            stop_hist_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            ring_cnt_q    <= ring_cnt_d;
            snooze_cnt_q  <= snooze_cnt_d;
            beep_q        <= beep_d;
            left_q        <= left_d;
            missed_q      <= missed_d;
            buzzer_q      <= buzzer_d;
            snooze_hist_q <= snooze_btn;
            stop_hist_q   <= stop_btn;
        end
    end

    assign ringing     = (state_q == StRinging);
    assign snoozed     = (state_q == StSnoozed);
    assign buzzer      = buzzer_q;
    assign snooze_left = left_q;
    assign missed      = missed_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed vector bench for alarm_controller with short timeouts (5 s ring, 3 s snooze, 2 snoozes).
module tb_alarm_controller;

    localparam int unsigned RingS   = 5;
    localparam int unsigned SnoozeS = 3;
    localparam int unsigned MaxSn   = 2;
    localparam int unsigned SlW     = $clog2(MaxSn + 1);

    logic           clk_in = 1'b0;
    logic           reset;
    logic           tick_1hz;
    logic [4:0]     hours;
    logic [5:0]     minutes;
    logic [5:0]     seconds;
    logic [4:0]     alarm_hours;
    logic [5:0]     alarm_minutes;
    logic           alarm_enable;
    logic           snooze_btn;
    logic           stop_btn;
    logic           ringing;
    logic           snoozed;
    logic           buzzer;
    logic [SlW-1:0] snooze_left;
    logic           missed;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    alarm_controller #(
        .RING_TIMEOUT_S(RingS),
        .SNOOZE_S      (SnoozeS),
        .MAX_SNOOZES   (MaxSn)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .tick_1hz     (tick_1hz),
        .hours        (hours),
        .minutes      (minutes),
        .seconds      (seconds),
        .alarm_hours  (alarm_hours),
        .alarm_minutes(alarm_minutes),
        .alarm_enable (alarm_enable),
        .snooze_btn   (snooze_btn),
        .stop_btn     (stop_btn),
        .ringing      (ringing),
        .snoozed      (snoozed),
        .buzzer       (buzzer),
        .snooze_left  (snooze_left),
        .missed       (missed)
    );

    typedef struct {
        bit tick;
        int hh, mm, ss;
        bit en, snz, stp;
        bit e_ring, e_snzd, e_buz;
        int e_left;
        bit e_miss;
    } vec_t;

    vec_t vecs[$];

    task automatic put(input bit tick, input int hh, input int mm, input int ss,
                       input bit en, input bit snz, input bit stp,
                       input bit e_ring, input bit e_snzd, input bit e_buz,
                       input int e_left, input bit e_miss);
        vec_t v;
        v.tick = tick; v.hh = hh; v.mm = mm; v.ss = ss;
        v.en = en; v.snz = snz; v.stp = stp;
        v.e_ring = e_ring; v.e_snzd = e_snzd; v.e_buz = e_buz;
        v.e_left = e_left; v.e_miss = e_miss;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input bit e_ring, input bit e_snzd,
                         input bit e_buz, input int e_left, input bit e_miss);
        checks++;
        if (ringing !== e_ring || snoozed !== e_snzd || buzzer !== e_buz ||
            snooze_left !== SlW'(e_left) || missed !== e_miss) begin
            errors++;
            $display("FAIL %s: got ring=%b snz=%b buz=%b left=%0d miss=%b, want ring=%b snz=%b buz=%b left=%0d miss=%b",
                     name, ringing, snoozed, buzzer, snooze_left, missed,
                     e_ring, e_snzd, e_buz, e_left, e_miss);
        end
    endtask

    task automatic drive(input bit tick, input int hh, input int mm, input int ss,
                         input bit en, input bit snz, input bit stp);
        tick_1hz     = tick;
        hours        = 5'(hh);
        minutes      = 6'(mm);
        seconds      = 6'(ss);
        alarm_enable = en;
        snooze_btn   = snz;
        stop_btn     = stp;
    endtask

    initial begin
        reset = 1'b1;
        alarm_hours = 5'd7;
        alarm_minutes = 6'd30;
        drive(0, 7, 29, 59, 1, 0, 0);

        //   tick hh mm ss en snz stp | ring snzd buz left miss
        // Trigger qualification
        put(0, 7, 29, 59, 1, 0, 0,   0, 0, 0, 2, 0);
        put(1, 7, 30,  1, 1, 0, 0,   0, 0, 0, 2, 0);
        put(1, 7, 30,  0, 0, 0, 0,   0, 0, 0, 2, 0);
        put(0, 7, 30,  0, 1, 0, 0,   0, 0, 0, 2, 0);
        put(1, 7, 31,  0, 1, 0, 0,   0, 0, 0, 2, 0);
        put(1, 8, 30,  0, 1, 0, 0,   0, 0, 0, 2, 0);
        put(1, 7, 30,  0, 1, 0, 0,   1, 0, 1, 2, 0);
        // Timeout: buzzer 1,0,1,0,1 then missed pulse
        put(0, 7, 30,  1, 1, 0, 0,   1, 0, 1, 2, 0);
        put(1, 7, 30,  1, 1, 0, 0,   1, 0, 0, 2, 0);
        put(1, 7, 30,  2, 1, 0, 0,   1, 0, 1, 2, 0);
        put(1, 7, 30,  3, 1, 0, 0,   1, 0, 0, 2, 0);
        put(1, 7, 30,  4, 1, 0, 0,   1, 0, 1, 2, 0);
        put(1, 7, 30,  5, 1, 0, 0,   0, 0, 0, 2, 1);
        put(0, 7, 30,  5, 1, 0, 0,   0, 0, 0, 2, 0);
        // Snooze budget
        put(1, 7, 30,  0, 1, 0, 0,   1, 0, 1, 2, 0);
        put(0, 7, 30,  1, 1, 1, 0,   0, 1, 0, 1, 0);
        put(1, 7, 30,  1, 1, 1, 0,   0, 1, 0, 1, 0);
        put(1, 7, 30,  2, 1, 0, 0,   0, 1, 0, 1, 0);
        put(1, 7, 30,  3, 1, 0, 0,   1, 0, 1, 1, 0);
        put(0, 7, 30,  3, 1, 1, 0,   0, 1, 0, 0, 0);
        put(1, 7, 30,  4, 1, 0, 0,   0, 1, 0, 0, 0);
        put(1, 7, 30,  5, 1, 0, 0,   0, 1, 0, 0, 0);
        put(1, 7, 30,  6, 1, 0, 0,   1, 0, 1, 0, 0);
        put(0, 7, 30,  6, 1, 1, 0,   1, 0, 1, 0, 0);
        put(1, 7, 30,  7, 1, 0, 0,   1, 0, 0, 0, 0);
        put(0, 7, 30,  7, 1, 0, 1,   0, 0, 0, 2, 0);
        put(0, 7, 30,  7, 1, 0, 0,   0, 0, 0, 2, 0);
        // Stop and snooze in the same cycle
        put(1, 7, 30,  0, 1, 0, 0,   1, 0, 1, 2, 0);
        put(0, 7, 30,  0, 1, 1, 1,   0, 0, 0, 2, 0);
        put(0, 7, 30,  0, 1, 0, 0,   0, 0, 0, 2, 0);
        // Enable dropped while snoozed
        put(1, 7, 30,  0, 1, 0, 0,   1, 0, 1, 2, 0);
        put(0, 7, 30,  1, 1, 1, 0,   0, 1, 0, 1, 0);
        put(0, 7, 30,  1, 0, 0, 0,   0, 0, 0, 2, 0);
        put(1, 7, 30,  2, 1, 0, 0,   0, 0, 0, 2, 0);
        put(1, 7, 30,  3, 1, 0, 0,   0, 0, 0, 2, 0);
        put(1, 7, 30,  4, 1, 0, 0,   0, 0, 0, 2, 0);
        // Stop coinciding with the timeout tick: no missed pulse
        put(1, 7, 30,  0, 1, 0, 0,   1, 0, 1, 2, 0);
        put(1, 7, 30,  1, 1, 0, 0,   1, 0, 0, 2, 0);
        put(1, 7, 30,  2, 1, 0, 0,   1, 0, 1, 2, 0);
        put(1, 7, 30,  3, 1, 0, 0,   1, 0, 0, 2, 0);
        put(1, 7, 30,  4, 1, 0, 0,   1, 0, 1, 2, 0);
        put(1, 7, 30,  5, 1, 0, 1,   0, 0, 0, 2, 0);
        put(0, 7, 30,  5, 1, 0, 0,   0, 0, 0, 2, 0);

        repeat (2) @(posedge clk_in);
        #1;
        check("reset_state", 0, 0, 0, 2, 0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].tick, vecs[i].hh, vecs[i].mm, vecs[i].ss,
                  vecs[i].en, vecs[i].snz, vecs[i].stp);
            @(posedge clk_in);
            #1;
            check($sformatf("vec%0d", i), vecs[i].e_ring, vecs[i].e_snzd,
                  vecs[i].e_buz, vecs[i].e_left, vecs[i].e_miss);
        end

        // Asynchronous reset mid-ring with snooze held through release
        drive(1, 7, 30, 0, 1, 0, 0);
        @(posedge clk_in);
        #1;
        check("rst_pre_ring", 1, 0, 1, 2, 0);
        drive(0, 7, 30, 1, 1, 1, 0);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async", 0, 0, 0, 2, 0);
        @(posedge clk_in);
        #3;
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk_in);
            #1;
            check($sformatf("rst_release%0d", k), 0, 0, 0, 2, 0);
        end
        drive(1, 7, 30, 1, 1, 1, 0);
        @(posedge clk_in);
        #1;
        check("rst_nomatch_tick", 0, 0, 0, 2, 0);
        drive(1, 7, 30, 0, 1, 1, 0);
        @(posedge clk_in);
        #1;
        check("rst_next_trigger", 1, 0, 1, 2, 0);
        drive(0, 7, 30, 0, 1, 1, 0);
        @(posedge clk_in);
        #1;
        check("rst_held_no_snooze", 1, 0, 1, 2, 0);
        drive(0, 7, 30, 0, 1, 0, 1);
        @(posedge clk_in);
        #1;
        check("rst_final_stop", 0, 0, 0, 2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Sequences the alarm behaviour of the clock: watches the running time from the seconds/minutes/hours counter chain and starts ringing when it matches the programmed alarm time. Manages ring timeout, snooze intervals and a snooze budget, using the 1 Hz tick from the prescaler counter as its only time base. Sits between the timekeeping counters, the debounced user buttons and the buzzer driver.

## Interface
- RING_TIMEOUT_S, 60: seconds of unattended ringing before giving up.
- SNOOZE_S, 540: snooze interval in seconds.
- MAX_SNOOZES, 3: snoozes allowed per alarm event; must be ≥ 1.
- SL_W, $clog2(MAX_SNOOZES+1): width of snooze_left.

Ports:
- clk_in  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- tick_1hz  in  1  one-cycle pulse once per second (prescaler max_reached).
- hours  in  5  current hour, 0–23.
- minutes  in  6  current minute, 0–59.
- seconds  in  6  current second, 0–59.
- alarm_hours  in  5  programmed alarm hour.
- alarm_minutes  in  6  programmed alarm minute.
- alarm_enable  in  1  level; alarm armed when high.
- snooze_btn  in  1  debounced level, synchronous to clk_in.
- stop_btn  in  1  debounced level, synchronous to clk_in.
- ringing  out  1  high in RINGING.
- snoozed  out  1  high in SNOOZED.
- buzzer  out  1  buzzer drive; 1 Hz on/off pattern while ringing.
- snooze_left  out  SL_W  snoozes remaining for the current event.
- missed  out  1  one-cycle pulse when ringing times out.

## Operation
- Reset values: ringing=0, snoozed=0, buzzer=0, missed=0, snooze_left=MAX_SNOOZES, state IDLE, all internal counters 0, button history registers 1.
- Button edges: snooze_edge = snooze_btn & ~snooze_q, stop_edge = stop_btn & ~stop_q. History registers reset to 1, so a button held through reset release gives no edge.
- States: IDLE, RINGING, SNOOZED.
- Priority each cycle, highest first: alarm_enable=0, stop_edge, snooze_edge, tick-driven counters.
- alarm_enable=0 in any state: go to IDLE, reload snooze_left, clear counters.
- IDLE → RINGING when tick_1hz & alarm_enable & hours==alarm_hours & minutes==alarm_minutes & seconds==0. Triggers once per day. Entry sets ring_cnt=0 and beep_phase=1.
- RINGING:
  - stop_edge → IDLE, reload snooze_left.
  - snooze_edge with snooze_left>0 → SNOOZED, snooze_left−1, snooze_cnt=0.
  - snooze_edge with snooze_left=0 is ignored.
  - each tick: ring_cnt+1 and beep_phase toggles.
  - tick with ring_cnt==RING_TIMEOUT_S−1 → IDLE, pulse missed, reload snooze_left.
- SNOOZED:
  - stop_edge → IDLE, reload snooze_left.
  - snooze_edge is ignored.
  - each tick: snooze_cnt+1.
  - tick with snooze_cnt==SNOOZE_S−1 → RINGING, ring_cnt=0, beep_phase=1.
- buzzer = ringing & beep_phase, registered.
- Counter widths: $clog2(RING_TIMEOUT_S) and $clog2(SNOOZE_S). Counters compare against the limit and never wrap.
- Time inputs must be stable in the tick cycle; they are sampled only when tick_1hz=1.

## Timing
- All outputs are registered. State changes appear one cycle after the causing tick or edge cycle.
- Trigger tick at cycle N → ringing=1 and buzzer=1 at N+1.
- Ringing lasts exactly RING_TIMEOUT_S ticks; missed is high for exactly one cycle.
- Snooze interval is exactly SNOOZE_S ticks after entering SNOOZED.
- Buzzer pattern: on for the first second, off for the next, and so on.
- A stop and snooze edge in the same cycle resolve as stop.
- A stop edge coinciding with the timeout tick goes to IDLE with no missed pulse.
- Reset mid-operation returns to reset values immediately (asynchronous); no pending event is resumed.

## Test plan
Use RING_TIMEOUT_S=5, SNOOZE_S=3, MAX_SNOOZES=2.
- Trigger: alarm 07:30, enable=1, tick at 07:30:00 → ringing=1, buzzer=1 next cycle. Same stimulus with enable=0, or tick at 07:30:01, → stays IDLE.
- Timeout: after trigger, no buttons, 5 ticks → ringing=0 after the 5th tick, missed high 1 cycle, snooze_left=2. Buzzer sequence 1,0,1,0,1.
- Snooze budget:
  - snooze edge → snoozed=1, snooze_left=1; after 3 ticks ringing=1.
  - snooze → snooze_left=0; after 3 ticks ringing=1.
  - third snooze edge → ignored, ringing stays 1.
  - stop → IDLE, snooze_left=2.
- Simultaneous stop and snooze rising in the same cycle while RINGING → IDLE, snooze_left=2, snoozed never asserts.
- Reset asserted mid-RINGING with snooze_btn held through release → all outputs at reset values, no snooze on release, no ringing until the next matching tick.
- alarm_enable dropped during SNOOZED → IDLE next cycle; no re-ring after 3 further ticks.
